// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the FRANK6000 program-counter sequencer:
// reset vector, default geometry and the per-cycle action encoding.
package pc_sequencer_pkg;
  localparam int unsigned RESET_VECTOR      = 0;
  localparam int unsigned FRANK_ADDR_W      = 8;
  localparam int unsigned FRANK_STACK_DEPTH = 4;

  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_FAULT,
    ACT_RET,
    ACT_CALL,
    ACT_JUMP,
    ACT_INC
  } action_t;
endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO. Only the occupancy count is reset; entry contents
// are don't-care until written by a push.
module ret_stack #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [ADDR_W-1:0]        din,
  output logic [ADDR_W-1:0]        dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] mem [DEPTH];

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[PW'(count - CW'(1))];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (push && !full)
      count <= count + CW'(1);
    else if (pop && !empty)
      count <= count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[PW'(count)] <= din;
  end
endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: increment / taken jump / call / return with a
// sticky stack-fault flag that freezes the machine until reset.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int ADDR_W      = FRANK_ADDR_W,
  parameter int STACK_DEPTH = FRANK_STACK_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          is_branch,
  input  logic                          jump,
  input  logic                          call,
  input  logic                          ret,
  input  logic [ADDR_W-1:0]             target,
  output logic [ADDR_W-1:0]             pc,
  output logic [$clog2(STACK_DEPTH):0]  sp,
  output logic                          stack_err
);
  action_t           act;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] top;
  logic              err_next;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;

  assign pc_inc = pc + ADDR_W'(1);

  // Priority: fault > ret > call > taken jump > increment.
  always_comb begin
    act = ACT_HOLD;
    if (en && !stack_err) begin
      if (call && ret)             act = ACT_FAULT;
      else if (ret)                act = ACT_RET;
      else if (call)               act = ACT_CALL;
      else if (is_branch && jump)  act = ACT_JUMP;
      else                         act = ACT_INC;
    end
  end

  always_comb begin
    pc_next  = pc;
    err_next = stack_err;
    push     = 1'b0;
    pop      = 1'b0;
    case (act)
      ACT_FAULT: err_next = 1'b1;
      ACT_RET: begin
        if (empty) err_next = 1'b1;
        else begin
          pop     = 1'b1;
          pc_next = top;
        end
      end
      ACT_CALL: begin
        if (full) err_next = 1'b1;
        else begin
          push    = 1'b1;
          pc_next = target;
        end
      end
      ACT_JUMP: pc_next = target;
      ACT_INC:  pc_next = pc_inc;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= ADDR_W'(RESET_VECTOR);
      stack_err <= 1'b0;
    end else begin
      pc        <= pc_next;
      stack_err <= err_next;
    end
  end

  ret_stack #(.ADDR_W(ADDR_W), .DEPTH(STACK_DEPTH)) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .dout  (top),
    .count (sp),
    .full  (full),
    .empty (empty)
  );
endmodule
